id_issue_buffer: RTL and testbench

Decoupling buffer between the decode stage and `issue_stage`, holding decoded `scoreboard_entry_t` instructions in a small FIFO. It absorbs issue back-pressure without stalling decode every cycle. It also enforces the single-unresolved-branch rule: a control-flow instruction is held at the head until the previously issued one is resolved by EX. `flush_i` discards all buffered state in one cycle.

---
 rtl/id_issue_buffer.sv | 107 ++++++++++
 tb/tb_id_issue_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_buffer.sv
// Decode-to-issue FIFO that holds a control-flow head while an earlier branch is unresolved.
// One-cycle latency (zero when ID_ISSUE_BUF_BYPASS_EN is defined and the buffer is empty); a full buffer refuses decode.
module id_issue_buffer #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [ENTRY_W-1:0]         decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output logic [ENTRY_W-1:0]         issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       issue_is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  input  logic                       resolve_branch_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic                       branch_pending_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_ctrl;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_branch_pending;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_pop_mem;
  logic               w_write;
  logic               w_head_vld;
  logic               w_head_ctrl;
  logic [ENTRY_W-1:0] w_head_instr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));

  // Ack is independent of the issue side: a full buffer refuses even if the head pops.
  assign decoded_instr_ack_o = !w_full && !flush_i;
  assign w_push              = decoded_instr_valid_i && decoded_instr_ack_o;

  always_comb begin
    w_head_instr = r_mem[r_rd_ptr];
    w_head_ctrl  = r_ctrl[r_rd_ptr];
    w_head_vld   = !w_empty;
`ifdef ID_ISSUE_BUF_BYPASS_EN
    if (w_empty) begin
      w_head_instr = decoded_instr_i;
      w_head_ctrl  = is_ctrl_flow_i;
      w_head_vld   = decoded_instr_valid_i;
    end
`endif
  end

  assign issue_instr_o        = w_head_instr;
  assign issue_is_ctrl_flow_o = w_head_ctrl;
  assign issue_instr_valid_o  = w_head_vld && !flush_i && !(w_head_ctrl && r_branch_pending);

  assign w_pop     = issue_instr_valid_o && issue_instr_ack_i;
  // An empty-buffer pop can only be a bypassed entry; it never touches storage.
  assign w_pop_mem = w_pop && !w_empty;
  assign w_write   = w_push && !(w_pop && w_empty);

  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr]  <= decoded_instr_i;
      r_ctrl[r_wr_ptr] <= is_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_cnt            <= '0;
      r_branch_pending <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_cnt            <= '0;
      r_branch_pending <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_mem) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_write, w_pop_mem})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      // A newly popped branch wins over a same-cycle resolve: it becomes the outstanding one.
      if (w_pop && w_head_ctrl) r_branch_pending <= 1'b1;
      else if (resolve_branch_i) r_branch_pending <= 1'b0;
    end
  end

  assign usage_o          = r_cnt;
  assign branch_pending_o = r_branch_pending;

endmodule

// File: tb/tb_id_issue_buffer.sv
// Scoreboard bench for id_issue_buffer: directed stimulus queues expected issues, a monitor checks them.
module tb_id_issue_buffer;

  localparam int DEPTH = 4;
`ifdef ID_ISSUE_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] e;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] din = '0;
  logic        dvld = 1'b0;
  logic        dctrl = 1'b0;
  logic        dack;
  logic [31:0] iout;
  logic        ivld;
  logic        ictrl;
  logic        iack = 1'b0;
  logic        resolve = 1'b0;
  logic [2:0]  usage;
  logic        bp;

  int   checks = 0;
  int   errors = 0;
  int   n_pop = 0;
  exp_t sb[$];

  id_issue_buffer #(.DEPTH(DEPTH), .ENTRY_W(32)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .decoded_instr_i       (din),
    .decoded_instr_valid_i (dvld),
    .is_ctrl_flow_i        (dctrl),
    .decoded_instr_ack_o   (dack),
    .issue_instr_o         (iout),
    .issue_instr_valid_o   (ivld),
    .issue_is_ctrl_flow_o  (ictrl),
    .issue_instr_ack_i     (iack),
    .resolve_branch_i      (resolve),
    .usage_o               (usage),
    .branch_pending_o      (bp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue monitor: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && ivld === 1'b1 && iack === 1'b1) begin
      checks++;
      n_pop++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %0h ctrl=%0b, nothing expected", iout, ictrl);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (iout !== x.e || ictrl !== x.c) begin
          errors++;
          $display("FAIL issue_order: got %0h ctrl=%0b expected %0h ctrl=%0b", iout, ictrl, x.e, x.c);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input int id);
    return {16'hC0DE, 16'(id)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int id, input logic c, input bit exp_acc);
    exp_t x;
    din   = mk(id);
    dctrl = c;
    dvld  = 1'b1;
    if (exp_acc) begin
      x.e = mk(id);
      x.c = c;
      sb.push_back(x);
    end
  endtask

  task automatic idle();
    dvld  = 1'b0;
    dctrl = 1'b0;
  endtask

  initial begin
    int base;
    int mcnt;
    int sent;
    bit acc;
    bit pop;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ivld), 0);
    chk("rst_dack", 32'(dack), 1);
    chk("rst_usage", 32'(usage), 0);
    chk("rst_bp", 32'(bp), 0);
    rst_n = 1'b1;

    // Fill to DEPTH with issue stalled
    for (int k = 0; k < DEPTH; k++) begin
      step(); offer(k, 1'b0, 1'b1); iack = 1'b0;
      @(negedge clk); chk("fill_dack", 32'(dack), 1);
    end
    step(); idle();
    @(negedge clk);
    chk("full_usage", 32'(usage), 4);
    chk("full_dack", 32'(dack), 0);
    // Full buffer refuses even while the head pops
    step(); offer(4, 1'b0, 1'b0); iack = 1'b1;
    @(negedge clk);
    chk("full_pop_dack", 32'(dack), 0);
    chk("full_pop_valid", 32'(ivld), 1);
    step(); idle();
    @(negedge clk); chk("after_pop_usage", 32'(usage), 3);
    step(); step(); step();
    @(negedge clk);
    chk("drain_usage", 32'(usage), 0);
    chk("empty_valid", 32'(ivld), 0);

    // Latency from empty
    step(); offer(10, 1'b0, 1'b1); iack = 1'b1;
    @(negedge clk); chk("lat_same_cycle_valid", 32'(ivld), 32'(BYP));
    step(); idle();
    @(negedge clk);
    chk("lat_usage", 32'(usage), BYP ? 0 : 1);
    chk("lat_next_valid", 32'(ivld), BYP ? 0 : 1);
    step();
    @(negedge clk); chk("lat_usage_end", 32'(usage), 0);

    // Branch, ADD, branch: second branch waits for resolve
    step(); iack = 1'b0; offer(20, 1'b1, 1'b1);
    step(); offer(21, 1'b0, 1'b1);
    step(); offer(22, 1'b1, 1'b1);
    step(); idle(); iack = 1'b1;
    @(negedge clk);
    chk("br1_valid", 32'(ivld), 1);
    chk("br1_bp_before", 32'(bp), 0);
    step();
    @(negedge clk);
    chk("add_bp", 32'(bp), 1);
    chk("add_valid", 32'(ivld), 1);
    step();
    @(negedge clk);
    chk("br2_held", 32'(ivld), 0);
    chk("br2_held_usage", 32'(usage), 1);
    step(); resolve = 1'b1;
    @(negedge clk); chk("br2_held_on_resolve", 32'(ivld), 0);
    step(); resolve = 1'b0;
    @(negedge clk);
    chk("br2_bp_cleared", 32'(bp), 0);
    chk("br2_issue", 32'(ivld), 1);
    step();
    @(negedge clk);
    chk("br2_bp_set", 32'(bp), 1);
    chk("br2_usage", 32'(usage), 0);

    // Resolve in the same cycle a new branch pops
    step(); iack = 1'b0; resolve = 1'b1;
    step(); resolve = 1'b0; offer(23, 1'b1, 1'b1);
    @(negedge clk); chk("sim_bp_clear", 32'(bp), 0);
    step(); idle(); iack = 1'b1; resolve = 1'b1;
    @(negedge clk); chk("sim_valid", 32'(ivld), 1);
    step(); iack = 1'b0; resolve = 1'b0;
    @(negedge clk); chk("sim_bp_stays", 32'(bp), 1);
    step(); resolve = 1'b1;
    step(); resolve = 1'b0;
    @(negedge clk); chk("sim_bp_resolved", 32'(bp), 0);

    // Flush with 3 entries and a pending branch
    step(); offer(30, 1'b1, 1'b1);
    step(); idle(); iack = 1'b1;
    step(); iack = 1'b0; offer(31, 1'b0, 1'b0);
    step(); offer(32, 1'b0, 1'b0);
    step(); offer(33, 1'b0, 1'b0);
    step(); idle();
    @(negedge clk);
    chk("pre_flush_usage", 32'(usage), 3);
    chk("pre_flush_bp", 32'(bp), 1);
    step(); flush = 1'b1; offer(34, 1'b0, 1'b0); iack = 1'b1; resolve = 1'b1;
    @(negedge clk);
    chk("flush_dack", 32'(dack), 0);
    chk("flush_valid", 32'(ivld), 0);
    step(); flush = 1'b0; idle(); iack = 1'b0; resolve = 1'b0;
    @(negedge clk);
    chk("post_flush_usage", 32'(usage), 0);
    chk("post_flush_bp", 32'(bp), 0);
    chk("post_flush_valid", 32'(ivld), 0);
    chk("post_flush_dack", 32'(dack), 1);

    // Streaming with random issue ack across pointer wrap
    void'($urandom(32'd12345));
    base = n_pop;
    mcnt = 0;
    sent = 0;
    for (int cyc = 0; cyc < 200 && (sent < 20 || mcnt > 0); cyc++) begin
      step();
      iack = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < 20) begin
        acc = (mcnt != DEPTH);
        pop = iack && (mcnt != 0 || BYP);
        offer(100 + sent, 1'b0, acc);
        if (acc) sent++;
      end else begin
        idle();
        acc = 1'b0;
        pop = iack && (mcnt != 0);
      end
      mcnt = mcnt + int'(acc) - int'(pop);
      @(negedge clk);
      if (dvld) chk("stream_dack", 32'(dack), 32'(acc));
    end
    step(); idle(); iack = 1'b0;
    @(negedge clk);
    chk("stream_pops", 32'(n_pop - base), 20);
    chk("stream_sb_empty", 32'(sb.size()), 0);
    chk("stream_usage", 32'(usage), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
